// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_pkg: shared constants and width helpers for router_sync_n            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_DATA_W  = 8;
  localparam int ROUTER_TIMEOUT = 30;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Never return zero so a 1-bit field still exists for degenerate counts.
  function automatic int ch_idx_w(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_timeout_ctr: per-FIFO unread-data watchdog with soft-reset pulse     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  input  logic clr_sticky,
  output logic sft_rst,
  output logic to_sticky
);

  localparam int CNT_W = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sft_rst_q, sft_rst_d;
  logic             to_sticky_q, to_sticky_d;
  logic             idle;

  always_comb begin
    idle        = vld & ~rd;
    cnt_d       = '0;
    sft_rst_d   = 1'b0;
    if (idle && (cnt_q == C_TERM)) begin
      sft_rst_d = 1'b1;
    end else if (idle) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A new timeout takes priority over a simultaneous clear.
    to_sticky_d = sft_rst_d ? 1'b1 : (clr_sticky ? 1'b0 : to_sticky_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sft_rst_q   <= 1'b0;
      to_sticky_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sft_rst_q   <= sft_rst_d;
      to_sticky_q <= to_sticky_d;
    end
  end

  assign sft_rst   = sft_rst_q;
  assign to_sticky = to_sticky_q;

endmodule : router_timeout_ctr
`default_nettype wire

// File: rtl/router_sync_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_sync_n: N-channel router synchronizer (address steer + timeouts)     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int DATA_W  = ROUTER_DATA_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_addr,
  input  logic              wr_enb_reg,
  input  logic [DATA_W-1:0] din,
  input  logic [NUM_CH-1:0] rd_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] clr_sticky,
  output logic [NUM_CH-1:0] vld_out,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] wr_enb,
  output logic [NUM_CH-1:0] sft_rst,
  output logic              addr_err,
  output logic [NUM_CH-1:0] to_sticky
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam logic [31:0] C_NUM_CH = 32'(NUM_CH);

  logic [CH_W-1:0] sel_q, sel_d;
  logic            addr_err_q, addr_err_d;

  always_comb begin
    sel_d      = sel_q;
    addr_err_d = addr_err_q;
    if (detect_addr) begin
      sel_d      = din[CH_W-1:0];
      addr_err_d = (32'(din[CH_W-1:0]) >= C_NUM_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Decode from the registered sel so a header's address steers from the next cycle.
  always_comb begin
    wr_enb    = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err_q && (sel_q == CH_W'(i))) begin
        wr_enb[i] = wr_enb_reg;
        fifo_full = full[i];
      end
    end
  end

  assign vld_out  = ~empty;
  assign addr_err = addr_err_q;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      router_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
      ) u_timeout_ctr (
        .clk        (clk),
        .rst        (rst),
        .vld        (vld_out[g]),
        .rd         (rd_enb[g]),
        .clr_sticky (clr_sticky[g]),
        .sft_rst    (sft_rst[g]),
        .to_sticky  (to_sticky[g])
      );
    end
  endgenerate

endmodule : router_sync_n
`default_nettype wire

// File: tb/tb_router_sync_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_router_sync_n: directed self-checking bench, 3ch/T30 and 5ch/T4 builds   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_router_sync_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 3-channel, TIMEOUT=30 instance
  logic       a_detect, a_wreg;
  logic [7:0] a_din;
  logic [2:0] a_rd, a_empty, a_full, a_clr;
  logic [2:0] a_vld, a_wr, a_sft, a_sticky;
  logic       a_ffull, a_aerr;

  // 5-channel, TIMEOUT=4 instance
  logic       b_detect, b_wreg;
  logic [7:0] b_din;
  logic [4:0] b_rd, b_empty, b_full, b_clr;
  logic [4:0] b_vld, b_wr, b_sft, b_sticky;
  logic       b_ffull, b_aerr;

  int tests_run = 0;
  int tests_failed = 0;

  router_sync_n #(.NUM_CH(3), .DATA_W(8), .TIMEOUT(30)) u_dut_a (
    .clk(clk), .rst(rst), .detect_addr(a_detect), .wr_enb_reg(a_wreg), .din(a_din),
    .rd_enb(a_rd), .empty(a_empty), .full(a_full), .clr_sticky(a_clr),
    .vld_out(a_vld), .fifo_full(a_ffull), .wr_enb(a_wr), .sft_rst(a_sft),
    .addr_err(a_aerr), .to_sticky(a_sticky)
  );

  router_sync_n #(.NUM_CH(5), .DATA_W(8), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .detect_addr(b_detect), .wr_enb_reg(b_wreg), .din(b_din),
    .rd_enb(b_rd), .empty(b_empty), .full(b_full), .clr_sticky(b_clr),
    .vld_out(b_vld), .fifo_full(b_ffull), .wr_enb(b_wr), .sft_rst(b_sft),
    .addr_err(b_aerr), .to_sticky(b_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_detect = 0; a_wreg = 0; a_din = 0; a_rd = 0; a_empty = 3'b111; a_full = 3'b001; a_clr = 0;
    b_detect = 0; b_wreg = 0; b_din = 0; b_rd = 0; b_empty = 5'b11111; b_full = 0; b_clr = 0;
    tick(); tick();
    check("rst_sft", a_sft, 0);
    check("rst_sticky", a_sticky, 0);
    check("rst_aerr", a_aerr, 0);
    check("rst_wr", a_wr, 0);
    check("rst_ffull_sel0", a_ffull, 1);
    check("rst_vld", a_vld, 3'b000);

    // Header and write together: the old sel (0) still steers this cycle.
    rst = 1'b0;
    a_detect = 1; a_din = 8'h02; a_wreg = 1; a_full = 3'b100;
    #1;
    check("steer_old_sel", a_wr, 3'b001);
    check("ffull_old_sel", a_ffull, 0);
    tick();
    a_detect = 0;
    #1;
    check("steer_ch2", a_wr, 3'b100);
    check("ffull_ch2", a_ffull, 1);
    check("aerr_ch2", a_aerr, 0);

    // Address 3 is out of range for 3 channels.
    a_detect = 1; a_din = 8'h03; a_full = 3'b111;
    tick();
    a_detect = 0;
    #1;
    check("aerr_set", a_aerr, 1);
    check("wr_suppressed", a_wr, 0);
    check("ffull_invalid", a_ffull, 0);

    // Upper din bits are ignored: 0x11 addresses channel 1.
    a_detect = 1; a_din = 8'h11; a_full = 3'b010;
    tick();
    a_detect = 0;
    #1;
    check("aerr_clear", a_aerr, 0);
    check("steer_ch1", a_wr, 3'b010);
    check("ffull_ch1", a_ffull, 1);
    a_wreg = 0;
    #1;
    check("wr_idle", a_wr, 0);

    // Channel 1 idle: pulse on the 30th edge, then again 30 edges later.
    a_empty = 3'b101;
    #1;
    check("vld_ch1", a_vld, 3'b010);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("to1_k%0d", k), a_sft, (k == 30) ? 3'b010 : 3'b000);
    end
    check("sticky_set", a_sticky, 3'b010);
    for (int k = 1; k <= 30; k++) begin
      if (k == 30) a_clr = 3'b010;
      tick();
      check($sformatf("to2_k%0d", k), a_sft, (k == 30) ? 3'b010 : 3'b000);
    end
    check("sticky_set_wins", a_sticky, 3'b010);
    a_empty = 3'b111;
    tick();
    check("sticky_cleared", a_sticky, 0);
    check("no_pulse_empty", a_sft, 0);
    a_clr = 0;

    // Read on the terminal cycle prevents the pulse and restarts the count.
    a_empty = 3'b101;
    for (int k = 1; k <= 29; k++) begin
      tick();
      check($sformatf("rescue_k%0d", k), a_sft, 0);
    end
    a_rd = 3'b010;
    tick();
    check("rescue_terminal", a_sft, 0);
    a_rd = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("restart_k%0d", k), a_sft, (k == 30) ? 3'b010 : 3'b000);
    end

    // Reset mid-count (count at 29) kills the pending pulse.
    a_empty = 3'b111; tick(); a_empty = 3'b101;
    for (int k = 1; k <= 29; k++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_sft", a_sft, 0);
    check("rst_mid_sticky", a_sticky, 0);
    rst = 1'b0;
    tick();
    check("post_rst_sft", a_sft, 0);
    a_empty = 3'b111;

    // 5-channel build: address 4 is the last legal channel, 5 is not.
    b_detect = 1; b_din = 8'h04;
    tick();
    b_detect = 0; b_wreg = 1;
    #1;
    check("b_steer_ch4", b_wr, 5'b10000);
    check("b_aerr_ch4", b_aerr, 0);
    b_detect = 1; b_din = 8'h05;
    tick();
    b_detect = 0;
    #1;
    check("b_aerr_ch5", b_aerr, 1);
    check("b_wr_suppressed", b_wr, 0);
    b_wreg = 0;

    // Channels 0 and 3 idle together: simultaneous pulses every 4 edges.
    b_empty = 5'b10110;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("b_to_k%0d", k), b_sft, (k % 4 == 0) ? 5'b01001 : 5'b00000);
    end
    check("b_sticky", b_sticky, 5'b01001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_router_sync_n
`default_nettype wire

// File: doc/router_sync_n.md
# router_sync_n

Parametrised successor to the 1x3 router synchronizer. It generalises the router's write-side/read-side glue to NUM_CH output FIFOs. It latches the destination address on header detection and steers write enables and the full flag to the addressed FIFO. Per channel, it raises a valid flag and issues a one-cycle soft-reset pulse when a FIFO holds data unread for TIMEOUT consecutive cycles. New over the 3-channel version:
- out-of-range address detection with write suppression;
- clean, defined soft-reset pulses;
- a sticky per-channel timeout status.

## Interface
Parameters:
- NUM_CH, 3: number of output channels/FIFOs; legal range 2..8.
- DATA_W, 8: width of din.
- TIMEOUT, 30: consecutive unread cycles before soft reset; legal range 2..255.
- CH_W (localparam), clog2(NUM_CH): address field width, taken from din[CH_W-1:0].
- CNT_W (localparam), clog2(TIMEOUT): per-channel counter width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  reset, synchronous and active-high.
- detect_addr  in  1  header byte present on din; latch address.
- wr_enb_reg  in  1  FSM request to write current byte.
- din  in  DATA_W  packet byte; low CH_W bits are the address on header.
- rd_enb  in  NUM_CH  per-channel read enable from downstream.
- empty  in  NUM_CH  per-FIFO empty.
- full  in  NUM_CH  per-FIFO full.
- vld_out  out  NUM_CH  combinational ~empty.
- fifo_full  out  1  full flag of the addressed FIFO; 0 if address invalid.
- wr_enb  out  NUM_CH  one-hot write enable to the addressed FIFO.
- sft_rst  out  NUM_CH  registered one-cycle soft-reset pulse per FIFO.
- addr_err  out  1  registered; latched address >= NUM_CH.
- to_sticky  out  NUM_CH  registered; set on channel timeout, cleared by rst or clr_sticky.
- clr_sticky  in  NUM_CH  per-channel clear of to_sticky.

## Operation
- Address register sel (CH_W bits):
  - On each clk edge with detect_addr=1, sel <= din[CH_W-1:0] and addr_err <= (din[CH_W-1:0] >= NUM_CH).
  - Otherwise sel and addr_err hold their values.
- wr_enb: combinational.
  - When wr_enb_reg=1 and addr_err=0, wr_enb = 1<<sel; otherwise 0.
  - Always zero or one-hot.
- fifo_full: combinational, equals full[sel] when addr_err=0, else 0.
- vld_out[i] = ~empty[i]; no registering.
- Per-channel timeout counter cnt[i]. At each edge:
  - idle[i] = vld_out[i] & ~rd_enb[i].
  - If idle[i] and cnt[i] == TIMEOUT-1: sft_rst[i] <= 1, cnt[i] <= 0.
  - Else if idle[i]: cnt[i] <= cnt[i]+1, sft_rst[i] <= 0.
  - Else: cnt[i] <= 0, sft_rst[i] <= 0.
- to_sticky[i] is set on the same edge that sets sft_rst[i]. clr_sticky[i] clears it. Set wins if both occur together.
- Reset values, all on rst=1 at an edge: sel=0, addr_err=0, cnt=0, sft_rst=0, to_sticky=0. Combinational outputs follow the reset state: wr_enb=0 unless wr_enb_reg=1, fifo_full=full[0].

## Timing
- Address latency is 1 cycle. If detect_addr and wr_enb_reg are high in the same cycle, wr_enb decodes the previous sel; the new address steers from the next cycle.
- sft_rst[i] rises on the edge ending the TIMEOUT-th consecutive idle cycle and is high exactly one cycle.
- A channel that stays idle pulses again every TIMEOUT cycles.
- Any cycle with rd_enb[i]=1 or empty[i]=1 restarts the count from 0. A read on the terminal cycle prevents the pulse.
- Channels are independent: several sft_rst bits may pulse in the same cycle.
- rst mid-count clears cnt and any pending pulse on that edge. No pulse is emitted in the cycle after reset.
- cnt never exceeds TIMEOUT-1; no wrap beyond the terminal value.

## Structure
- Package router_pkg holds:
  - the clog2 function;
  - default constants ROUTER_NUM_CH=3, ROUTER_DATA_W=8, ROUTER_TIMEOUT=30;
  - the channel-index width helper.
- Sub-module router_timeout_ctr (parameter TIMEOUT; ports clk, rst, vld, rd, clr_sticky, sft_rst, to_sticky), instantiated NUM_CH times in a generate loop.
- The top level holds sel, addr_err, the wr_enb decode and the fifo_full mux.

## Test plan
- Reset check: rst=1 for 2 cycles with empty=all 1 -> sft_rst=0, to_sticky=0, addr_err=0, wr_enb=0.
- Address steering, NUM_CH=3: detect_addr with din=8'h02, then wr_enb_reg=1 -> wr_enb=3'b100 from the next cycle. With full[2]=1 -> fifo_full=1.
- Invalid address, NUM_CH=3: din=8'h03 with detect_addr -> addr_err=1 next cycle; wr_enb stays 0 with wr_enb_reg=1; fifo_full=0.
- Timeout, channel 1: empty[1]=0 and rd_enb[1]=0 for 30 cycles -> sft_rst[1] high on cycle 31 only, to_sticky[1]=1. Held idle for 30 more cycles -> second pulse.
- Read rescue: idle 29 cycles, rd_enb[1]=1 on cycle 30 -> no pulse; count restarts.
- Regeneration: NUM_CH=5, TIMEOUT=4. Address 4 steers wr_enb=5'b10000. Channels 0 and 3 idle together -> simultaneous sft_rst pulses after 4 cycles.
